// File: rtl/fifo_rd_checker.sv
// -----------------------------------------------------------------------------
// fifo_rd_checker
//
// Read-side consumer for the async FIFO. Drains a programmed number of words
// over a ready/valid port, optionally throttles ready with a free-running
// 8-bit LFSR, and checks every accepted word against the 32-bit Galois LFSR
// sequence produced by the matching write-side generator.
//
// Handshake: a word is transferred on a rising edge of io_rd_clk where
// io_read_valid && io_read_ready are both high. io_read_ready is a register
// and never depends combinationally on any input. io_read_bits is only
// looked at on a transfer edge.
//
// Ports:
//   io_rd_clk, io_rd_rst_n   clock / async active-low reset
//   io_start, io_len         start pulse and word count (sampled in IDLE)
//   io_stall_en              enable pseudo-random ready deassertion
//   io_read_valid/bits/ready FIFO read port
//   io_busy                  high while consuming words
//   io_done                  one-cycle pulse after the last word
//   io_pass                  last completed run had no mismatches
//   io_rx_count              words accepted in current/last run
//   io_err_count             mismatches in current/last run (saturating)
//   io_first_err_idx/data    index and received value of first mismatch
//   io_dbg_state             current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module fifo_rd_checker #(
  parameter int          DATA_W     = 32,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] SEED       = 32'h0000_0001,
  parameter logic [7:0]  STALL_SEED = 8'hA5
) (
  input  logic              io_rd_clk,
  input  logic              io_rd_rst_n,
  input  logic              io_start,
  input  logic [CNT_W-1:0]  io_len,
  input  logic              io_stall_en,
  input  logic              io_read_valid,
  input  logic [DATA_W-1:0] io_read_bits,
  output logic              io_read_ready,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_pass,
  output logic [CNT_W-1:0]  io_rx_count,
  output logic [CNT_W-1:0]  io_err_count,
  output logic [CNT_W-1:0]  io_first_err_idx,
  output logic [DATA_W-1:0] io_first_err_data,
  output logic [1:0]        io_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] EXP_MASK   = 32'h8020_0003;
  localparam logic [7:0]  STALL_MASK = 8'hB8;

  state_t              state_q;
  logic [31:0]         exp_q;
  logic [7:0]          stall_q;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    rx_q;
  logic [CNT_W-1:0]    err_q;
  logic [CNT_W-1:0]    first_idx_q;
  logic [DATA_W-1:0]   first_data_q;
  logic                ready_q;
  logic                pass_q;

  logic [31:0]         exp_next;
  logic [7:0]          stall_next;
  logic                accept;
  logic                mismatch;
  logic                last_word;
  logic                ready_next;
  logic [CNT_W-1:0]    err_inc;

  always_comb begin
    exp_next   = exp_q[0] ? ((exp_q >> 1) ^ EXP_MASK) : (exp_q >> 1);
    stall_next = stall_q[0] ? ((stall_q >> 1) ^ STALL_MASK) : (stall_q >> 1);
    accept     = (state_q == RUN) && io_read_valid && ready_q;
    mismatch   = accept && (io_read_bits != exp_q);
    last_word  = (rx_q == len_q - CNT_W'(1));
    // Ready for the coming cycle uses the stall bit that will be current then.
    ready_next = !(io_stall_en && stall_next[0]);
    err_inc    = (err_q == {CNT_W{1'b1}}) ? err_q : err_q + CNT_W'(1);
  end

  always_ff @(posedge io_rd_clk or negedge io_rd_rst_n) begin
    if (!io_rd_rst_n) begin
      state_q      <= IDLE;
      exp_q        <= SEED;
      stall_q      <= STALL_SEED;
      len_q        <= '0;
      rx_q         <= '0;
      err_q        <= '0;
      first_idx_q  <= '0;
      first_data_q <= '0;
      ready_q      <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      stall_q <= stall_next;
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (io_start) begin
            rx_q         <= '0;
            err_q        <= '0;
            first_idx_q  <= '0;
            first_data_q <= '0;
            exp_q        <= SEED;
            len_q        <= io_len;
            if (io_len != '0) begin
              state_q <= RUN;
              pass_q  <= 1'b0;
              ready_q <= ready_next;
            end else begin
              // Empty run: counters are cleared, so it completes clean.
              state_q <= DONE;
              pass_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            rx_q  <= rx_q + CNT_W'(1);
            exp_q <= exp_next;
            if (mismatch) begin
              err_q <= err_inc;
              if (err_q == '0) begin
                first_idx_q  <= rx_q;
                first_data_q <= io_read_bits;
              end
            end
          end
          if (accept && last_word) begin
            state_q <= DONE;
            // err_q saturates and never returns to zero, so the final count
            // is zero only if it was zero and this word matched.
            pass_q  <= (err_q == '0) && !mismatch;
          end else begin
            ready_q <= ready_next;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign io_read_ready     = ready_q;
  assign io_busy           = (state_q == RUN);
  assign io_done           = (state_q == DONE);
  assign io_pass           = pass_q;
  assign io_rx_count       = rx_q;
  assign io_err_count      = err_q;
  assign io_first_err_idx  = first_idx_q;
  assign io_first_err_data = first_data_q;
  assign io_dbg_state      = state_q;

endmodule

// File: tb/tb_fifo_rd_checker.sv
module tb_fifo_rd_checker;

  localparam int          CNT_W = 16;
  localparam int          SW    = 1 + 3 * CNT_W + 32;
  localparam logic [31:0] SEED  = 32'h0000_0001;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              io_start = 1'b0;
  logic [CNT_W-1:0]  io_len = '0;
  logic              io_stall_en = 1'b0;
  logic              io_read_valid = 1'b0;
  logic [31:0]       io_read_bits = '0;
  logic              io_read_ready;
  logic              io_busy;
  logic              io_done;
  logic              io_pass;
  logic [CNT_W-1:0]  io_rx_count;
  logic [CNT_W-1:0]  io_err_count;
  logic [CNT_W-1:0]  io_first_err_idx;
  logic [31:0]       io_first_err_data;
  logic [1:0]        io_dbg_state;

  fifo_rd_checker dut (
    .io_rd_clk         (clk),
    .io_rd_rst_n       (rst_n),
    .io_start          (io_start),
    .io_len            (io_len),
    .io_stall_en       (io_stall_en),
    .io_read_valid     (io_read_valid),
    .io_read_bits      (io_read_bits),
    .io_read_ready     (io_read_ready),
    .io_busy           (io_busy),
    .io_done           (io_done),
    .io_pass           (io_pass),
    .io_rx_count       (io_rx_count),
    .io_err_count      (io_err_count),
    .io_first_err_idx  (io_first_err_idx),
    .io_first_err_data (io_first_err_data),
    .io_dbg_state      (io_dbg_state)
  );

  // ---------------- reference model helpers ----------------
  int checks = 0;
  int errors = 0;
  logic [SW-1:0] exp_q[$];
  logic [7:0]    stall_m;

  function automatic logic [31:0] lfsr32_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  function automatic logic [7:0] lfsr8_step(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
  endfunction

  // Backpressure pattern as the spec defines it: free-running from reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_m <= 8'hA5;
    else        stall_m <= lfsr8_step(stall_m);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},   io_read_ready,     0);
    chk({tag, "_busy"},    io_busy,           0);
    chk({tag, "_done"},    io_done,           0);
    chk({tag, "_pass"},    io_pass,           0);
    chk({tag, "_rx"},      io_rx_count,       0);
    chk({tag, "_err"},     io_err_count,      0);
    chk({tag, "_fidx"},    io_first_err_idx,  0);
    chk({tag, "_fdata"},   io_first_err_data, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (io_busy)
        chk("ready_vs_stall", io_read_ready, !(io_stall_en && stall_m[0]));
      else
        chk("ready_idle", io_read_ready, 0);
      if (io_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          logic [SW-1:0]    e;
          logic             e_pass;
          logic [CNT_W-1:0] e_rx, e_err, e_idx;
          logic [31:0]      e_data;
          e = exp_q.pop_front();
          {e_pass, e_rx, e_err, e_idx, e_data} = e;
          chk("sum_pass",  io_pass,           e_pass);
          chk("sum_rx",    io_rx_count,       e_rx);
          chk("sum_err",   io_err_count,      e_err);
          chk("sum_fidx",  io_first_err_idx,  e_idx);
          chk("sum_fdata", io_first_err_data, e_data);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT in IDLE. bad_idx forces word bad_idx to
  // be sent as expected^1; abort_after resets the DUT after that many words;
  // restart_at pulses io_start (len=2) on that run cycle.
  task automatic do_run(input int len, input bit stall, input int vpct,
                        input int cpct, input int bad_idx,
                        input int abort_after, input int restart_at);
    logic [31:0]      words[$];
    logic [31:0]      lf;
    logic [CNT_W-1:0] e_err, e_idx;
    logic [31:0]      e_data;
    logic             bad, rdy, aborted;
    int               k, cyc;
    lf = SEED; e_err = '0; e_idx = '0; e_data = '0;
    for (int i = 0; i < len; i++) begin
      logic [31:0] w;
      bad = (i == bad_idx) || (int'($urandom_range(99)) < cpct);
      if (i == bad_idx)  w = lf ^ 32'h1;
      else if (bad)      w = lf ^ (32'h1 << $urandom_range(31));
      else               w = lf;
      if (bad) begin
        if (e_err == '0) begin
          e_idx  = CNT_W'(i);
          e_data = w;
        end
        if (e_err != {CNT_W{1'b1}}) e_err = e_err + 1'b1;
      end
      words.push_back(w);
      lf = lfsr32_step(lf);
    end
    if (abort_after < 0)
      exp_q.push_back({(e_err == '0), CNT_W'(len), e_err, e_idx, e_data});

    io_stall_en = stall;
    io_len      = CNT_W'(len);
    io_start    = 1'b1;
    @(negedge clk);
    io_start = 1'b0;
    k = 0; cyc = 0; aborted = 1'b0;
    while (k < len && !aborted) begin
      rdy           = io_read_ready;
      io_read_valid = (int'($urandom_range(99)) < vpct);
      io_read_bits  = io_read_valid ? words[k] : $urandom();
      if (cyc == restart_at) begin
        io_start = 1'b1;
        io_len   = 16'd2;
      end
      @(negedge clk);
      io_start = 1'b0;
      if (io_read_valid && rdy) k++;
      cyc++;
      if (abort_after >= 0 && k == abort_after) begin
        io_read_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrun_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        aborted = 1'b1;
      end else if (cyc > 5000) begin
        chk("run_timeout", k, len);
        aborted = 1'b1;
      end
    end
    io_read_valid = 1'b0;
    if (!aborted) begin
      chk("done_latency", io_done, 1);
      chk("ready_in_done", io_read_ready, 0);
      @(negedge clk);
      chk("back_to_idle", io_dbg_state, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    chk("por_state", io_dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_run(8,  1'b0, 100, 0, -1, -1, -1);   // clean, no stalls
    do_run(4,  1'b0, 100, 0,  2, -1, -1);   // word 2 corrupted
    do_run(16, 1'b1,  60, 0, -1, -1, -1);   // stalls + valid gaps
    do_run(0,  1'b0, 100, 0, -1, -1, -1);   // empty run
    do_run(10, 1'b0,  80, 0, -1,  5, -1);   // reset mid-run
    do_run(3,  1'b0, 100, 0, -1, -1, -1);   // restarts from SEED
    do_run(6,  1'b0, 100, 0, -1, -1,  2);   // start during RUN ignored
    for (int r = 0; r < 10; r++)
      do_run($urandom_range(40, 1), 1'($urandom_range(1)),
             $urandom_range(100, 30), $urandom_range(30), -1, -1, -1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_checker.md
Name: fifo_rd_checker

Overview:
- Single-clock consumer for the read port of the async FIFO.
- Drains a programmed number of words over ready/valid and can apply pseudo-random backpressure.
- Checks each accepted word against the LFSR sequence used by the matching write-side generator, and reports counts, pass/fail and the first mismatch.
- Instantiated in the read clock domain, in bring-up benches and in the on-chip loopback self-test.

Parameters:
- DATA_W, 32, width of io_read_bits; must be 32.
- CNT_W, 16, width of the length and counter fields.
- SEED, 32'h0000_0001, initial value of the expected-data LFSR; must be nonzero.
- STALL_SEED, 8'hA5, initial value of the backpressure LFSR; must be nonzero.

Ports:
- io_rd_clk, in, 1, clock; all logic on the rising edge.
- io_rd_rst_n, in, 1, asynchronous active-low reset.
- io_start, in, 1, single-cycle start pulse; sampled only in IDLE.
- io_len, in, CNT_W, number of words to consume; sampled with io_start.
- io_stall_en, in, 1, enables pseudo-random deassertion of io_read_ready.
- io_read_valid, in, 1, FIFO read-side valid.
- io_read_bits, in, DATA_W, FIFO read-side data.
- io_read_ready, out, 1, checker ready to FIFO.
- io_busy, out, 1, high while in RUN.
- io_done, out, 1, one-cycle pulse at end of a run.
- io_pass, out, 1, high when the last completed run had zero errors.
- io_rx_count, out, CNT_W, words accepted in the current or last run.
- io_err_count, out, CNT_W, mismatches in the current or last run; saturates at all-ones.
- io_first_err_idx, out, CNT_W, index (0-based) of the first mismatching word.
- io_first_err_data, out, DATA_W, received data of the first mismatch.

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - All outputs 0: ready, busy, done, pass, all counts, first_err_idx, first_err_data.
  - Expected LFSR=SEED; stall LFSR=STALL_SEED.
- Expected LFSR:
  - 32-bit Galois form, polynomial x^32+x^22+x^2+x+1, tap mask 32'h8020_0003.
  - Next value: if lfsr[0]==1, next=(lfsr>>1)^mask; else next=lfsr>>1.
  - Advances only on an accepted word (valid&&ready).
  - Word k expected = SEED advanced k times; word 0 = SEED.
- Stall LFSR:
  - 8-bit Galois, tap mask 8'hB8.
  - Free-runs every cycle in every state after reset, and is not reset by io_start.
- FSM, IDLE:
  - ready=0, busy=0.
  - io_start with io_len!=0 -> RUN. Same edge: clear rx_count, err_count, first_err_idx, first_err_data and pass; load expected LFSR=SEED; latch io_len.
  - io_start with io_len==0 -> DONE. Counters cleared.
- FSM, RUN:
  - busy=1.
  - io_read_ready = !(io_stall_en && stall_lfsr[0]), registered from the next-state stall LFSR so ready has no combinational path from any input.
  - Accept when io_read_valid && io_read_ready.
  - On accept: rx_count+1. If io_read_bits != expected, then err_count+1 (saturating); if err_count was 0, capture first_err_idx=rx_count (pre-increment) and first_err_data=io_read_bits.
  - Accept while rx_count == len-1 -> DONE. Ready drops to 0 on the following cycle, so exactly len words are consumed.
  - io_start during RUN is ignored.
- FSM, DONE (one cycle):
  - io_done=1, ready=0, busy=0.
  - pass = (err_count==0), captured on entering DONE and held until the next accepted io_start.
  - Returns to IDLE the next cycle; io_start in DONE is ignored.
- Latency: io_done is asserted 1 cycle after the final accepting edge.
- Counter outputs hold their last-run values in IDLE until the next start.
- io_len==CNT_W'hFFFF is a legal length; rx_count must not wrap within a run.
- Valid high with ready low: no accept, no LFSR advance, and data is not checked.
- Reset asserted mid-run: immediate return to reset values; the next run starts from SEED.
- io_read_bits is ignored when not accepted.

Test Plan:
- Reset, start len=8, stall_en=0, valid held high with the correct LFSR sequence -> ready high 8 consecutive cycles; rx_count=8, err_count=0; done pulse 1 cycle after the 8th accept; pass=1.
- Start len=4 with word 2 corrupted (expected ^ 32'h1) -> err_count=1, first_err_idx=2, first_err_data equals the corrupted value, pass=0.
- Start len=16, stall_en=1, random valid gaps -> exactly 16 accepts; ready low on cycles where stall bit0=1; no accept while ready=0; pass=1.
- Start len=0 -> done pulse on the next cycle, pass=1, rx_count=0, ready never asserted.
- Assert reset after 5 of 10 words, release, start len=3 -> counts restart; expected words SEED, then 32'h8020_0003, then 32'hC030_0002; pass=1.
- io_start pulsed during RUN with len=2 -> ignored; original len=6 run completes with rx_count=6.
